// File: rtl/jts16_obj_draw.sv
// jts16_obj_draw: sprite line drawer.
// Fetches 16-bit ROM words for one sprite and unpacks each into four 4-bit
// pixels. Each visible pixel is written to the line buffer at a column that
// starts at dr_xpos and steps by one (or down by one when dr_hflipb is set).
// Nibble 0 is transparent. Nibble 15 ends the sprite. A sprite also ends
// after MAXWORDS words if no end marker is found.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   dr_start / dr_busy    command strobe / command in progress
//   dr_xpos, dr_offset,   sprite parameters, latched on dr_start
//   dr_bank, dr_prio,     (dr_offset[15] = vertical flip: nibbles reversed
//   dr_pal, dr_hzoom,      and ROM words walked downwards)
//   dr_hflipb
//   obj_cs/addr/data/ok   ROM request, {bank, offset[14:0]}; held until obj_ok
//   bf_addr/data/we       line-buffer write port, data = {prio, pal, pixel}
//
// Optional build macro: JTS16_OBJ_HZOOM_EN enables horizontal shrink. A
// 5-bit accumulator adds dr_hzoom[4:0] for every nibble, and a pixel is
// dropped on each carry out.
//
// state | meaning
// IDLE  | waiting for dr_start
// FETCH | ROM request outstanding
// PIX   | emitting one nibble per cycle
// DONE  | one-cycle wrap-up, clears dr_busy

module jts16_obj_draw #(
   parameter int MAXWORDS = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dr_start,
   output logic        dr_busy,
   input  logic [8:0]  dr_xpos,
   input  logic [15:0] dr_offset,
   input  logic [3:0]  dr_bank,
   input  logic [1:0]  dr_prio,
   input  logic [5:0]  dr_pal,
   input  logic [9:0]  dr_hzoom,
   input  logic        dr_hflipb,
   output logic        obj_cs,
   output logic [18:0] obj_addr,
   input  logic [15:0] obj_data,
   input  logic        obj_ok,
   output logic [8:0]  bf_addr,
   output logic [11:0] bf_data,
   output logic        bf_we
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] PIX   = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam int WCW = $clog2(MAXWORDS + 1);

   logic [1:0]     st;
   logic [8:0]     col;
   logic [15:0]    offset;
   logic [3:0]     bank;
   logic [1:0]     prio;
   logic [5:0]     pal;
   logic           hflipb;
   logic [15:0]    word;
   logic [1:0]     nib_cnt;
   logic [WCW-1:0] wcnt;
   logic [3:0]     nib;
   logic           skip;
   logic           flip;

   assign flip     = offset[15];
   assign obj_cs   = (st == FETCH);
   assign obj_addr = {bank, offset[14:0]};

   // Without flip, the first nibble is bits 15:12. With flip, it is bits 3:0.
   always_comb begin
      nib = 4'd0;
      case (flip ? nib_cnt : ~nib_cnt)
         2'd3:    nib = word[15:12];
         2'd2:    nib = word[11:8];
         2'd1:    nib = word[7:4];
         default: nib = word[3:0];
      endcase
   end

`ifdef JTS16_OBJ_HZOOM_EN
   logic [4:0] hzoom;
   logic [4:0] acc;
   logic [5:0] acc_sum;
   logic       unused_hzoom;

   assign unused_hzoom = ^dr_hzoom[9:5];
   assign acc_sum      = {1'b0, acc} + {1'b0, hzoom};
   assign skip         = acc_sum[5];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hzoom <= 5'd0;
         acc   <= 5'd0;
      end else if (st == IDLE && dr_start) begin
         hzoom <= dr_hzoom[4:0];
         acc   <= 5'd0;
      end else if (st == PIX) begin
         acc <= acc_sum[4:0];
      end
   end
`else
   logic unused_hzoom;

   assign unused_hzoom = ^dr_hzoom;
   assign skip         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= IDLE;
         dr_busy <= 1'b0;
         col     <= 9'd0;
         offset  <= 16'd0;
         bank    <= 4'd0;
         prio    <= 2'd0;
         pal     <= 6'd0;
         hflipb  <= 1'b0;
         word    <= 16'd0;
         nib_cnt <= 2'd0;
         wcnt    <= '0;
         bf_we   <= 1'b0;
         bf_addr <= 9'd0;
         bf_data <= 12'd0;
      end else begin
         bf_we <= 1'b0;
         case (st)
            IDLE: if (dr_start) begin
               col     <= dr_xpos;
               offset  <= dr_offset;
               bank    <= dr_bank;
               prio    <= dr_prio;
               pal     <= dr_pal;
               hflipb  <= dr_hflipb;
               nib_cnt <= 2'd0;
               wcnt    <= '0;
               dr_busy <= 1'b1;
               st      <= FETCH;
            end
            FETCH: if (obj_ok) begin
               word    <= obj_data;
               nib_cnt <= 2'd0;
               st      <= PIX;
            end
            PIX: begin
               // The end marker wins even when zoom would drop this nibble.
               if (nib == 4'hf) begin
                  st <= DONE;
               end else begin
                  if (!skip) begin
                     if (nib != 4'h0) begin
                        bf_we   <= 1'b1;
                        bf_addr <= col;
                        bf_data <= {prio, pal, nib};
                     end
                     col <= hflipb ? col - 9'd1 : col + 9'd1;
                  end
                  nib_cnt <= nib_cnt + 2'd1;
                  if (nib_cnt == 2'd3) begin
                     offset <= {offset[15], flip ? offset[14:0] - 15'd1
                                                 : offset[14:0] + 15'd1};
                     wcnt   <= wcnt + 1'b1;
                     st     <= (wcnt == WCW'(MAXWORDS - 1)) ? DONE : FETCH;
                  end
               end
            end
            default: begin
               dr_busy <= 1'b0;
               st      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jts16_obj_draw.sv
// Directed bench for jts16_obj_draw. A behavioural ROM answers obj_cs after a
// programmable wait. Line-buffer writes and ROM fetch addresses are captured
// into queues and compared with hand-computed expectations.
// MAXWORDS is reduced to 4 so that forced termination can be reached quickly.
module tb_jts16_obj_draw;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dr_start = 1'b0;
   logic        dr_busy;
   logic [8:0]  dr_xpos = '0;
   logic [15:0] dr_offset = '0;
   logic [3:0]  dr_bank = '0;
   logic [1:0]  dr_prio = '0;
   logic [5:0]  dr_pal = '0;
   logic [9:0]  dr_hzoom = '0;
   logic        dr_hflipb = 1'b0;
   logic        obj_cs;
   logic [18:0] obj_addr;
   logic [15:0] obj_data = '0;
   logic        obj_ok = 1'b0;
   logic [8:0]  bf_addr;
   logic [11:0] bf_data;
   logic        bf_we;

   int ncmp = 0;
   int nfail = 0;
   int ok_delay = 0;
   int ok_wait = 0;
   int wr_col[$];
   int wr_dat[$];
   int fa[$];
   logic [15:0] rom [int];

   jts16_obj_draw #(.MAXWORDS(4)) dut (
      .clk(clk), .rst_n(rst_n), .dr_start(dr_start), .dr_busy(dr_busy),
      .dr_xpos(dr_xpos), .dr_offset(dr_offset), .dr_bank(dr_bank),
      .dr_prio(dr_prio), .dr_pal(dr_pal), .dr_hzoom(dr_hzoom),
      .dr_hflipb(dr_hflipb), .obj_cs(obj_cs), .obj_addr(obj_addr),
      .obj_data(obj_data), .obj_ok(obj_ok), .bf_addr(bf_addr),
      .bf_data(bf_data), .bf_we(bf_we)
   );

   always #5 clk = ~clk;

   // ROM model: unprogrammed addresses read as an end marker.
   always @(negedge clk) begin
      if (obj_cs) begin
         if (ok_wait >= ok_delay) begin
            obj_ok = 1'b1;
            obj_data = rom.exists(int'(obj_addr)) ? rom[int'(obj_addr)] : 16'hffff;
            fa.push_back(int'(obj_addr));
         end else begin
            obj_ok = 1'b0;
         end
         ok_wait++;
      end else begin
         obj_ok = 1'b0;
         ok_wait = 0;
      end
   end

   always @(negedge clk) begin
      if (rst_n && bf_we) begin
         wr_col.push_back(int'(bf_addr));
         wr_dat.push_back(int'(bf_data));
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int gcol(int i);
      return (i < wr_col.size()) ? wr_col[i] : -1;
   endfunction

   function automatic int gdat(int i);
      return (i < wr_dat.size()) ? wr_dat[i] : -1;
   endfunction

   function automatic int gfa(int i);
      return (i < fa.size()) ? fa[i] : -1;
   endfunction

   task automatic start_cmd(input string tag, input logic [8:0] x, input logic [15:0] off,
                            input logic [3:0] bk, input logic [1:0] pr,
                            input logic [5:0] pl, input logic [9:0] hz, input logic hf);
      wr_col.delete(); wr_dat.delete(); fa.delete();
      @(negedge clk);
      dr_xpos = x; dr_offset = off; dr_bank = bk; dr_prio = pr;
      dr_pal = pl; dr_hzoom = hz; dr_hflipb = hf; dr_start = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_lat_cs"}, obj_cs, 1);
      chk({tag, "_lat_addr"}, obj_addr, {bk, off[14:0]});
      @(negedge clk);
      dr_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (dr_busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_timeout"}, (n < 300), 1);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic scen_a(input string tag);
      start_cmd(tag, 9'd10, 16'h0100, 4'd2, 2'd1, 6'd5, 10'd0, 1'b0);
      wait_done(tag);
      chk({tag, "_nwr"}, wr_col.size(), 4);
      chk({tag, "_c0"}, gcol(0), 10);  chk({tag, "_d0"}, gdat(0), 12'h451);
      chk({tag, "_c1"}, gcol(1), 11);  chk({tag, "_d1"}, gdat(1), 12'h452);
      chk({tag, "_c2"}, gcol(2), 13);  chk({tag, "_d2"}, gdat(2), 12'h453);
      chk({tag, "_c3"}, gcol(3), 14);  chk({tag, "_d3"}, gdat(3), 12'h454);
      chk({tag, "_nfetch"}, fa.size(), 2);
      chk({tag, "_busy"}, dr_busy, 0);
   endtask

   initial begin
      int bad;
      int n;
      rom[32'h10100] = 16'h1203;
      rom[32'h10101] = 16'h4f00;
      rom[32'h100ff] = 16'hf000;
      rom[32'h00010] = 16'h123f;
      rom[32'h08200] = 16'h5fff;
      rom[32'h00300] = 16'h1111;
      rom[32'h00301] = 16'h1111;
      rom[32'h00302] = 16'hffff;
      for (int i = 0; i < 8; i++) rom[32'h400 + i] = 16'h0000;
      for (int i = 0; i < 4; i++) rom[32'h500 + i] = 16'h1111;

      // Reset values while rst_n is low
      repeat (3) @(negedge clk);
      chk("rst_busy", dr_busy, 0);
      chk("rst_cs", obj_cs, 0);
      chk("rst_addr", obj_addr, 0);
      chk("rst_we", bf_we, 0);
      chk("rst_baddr", bf_addr, 0);
      chk("rst_bdata", bf_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic sprite: transparent pixel, end marker in the second word
      scen_a("norm");
      chk("norm_fa0", gfa(0), 32'h10100);
      chk("norm_fa1", gfa(1), 32'h10101);

      // Flip: reversed nibbles, offset walks downwards
      start_cmd("flip", 9'd10, 16'h8100, 4'd2, 2'd1, 6'd5, 10'd0, 1'b0);
      wait_done("flip");
      chk("flip_nwr", wr_col.size(), 3);
      chk("flip_c0", gcol(0), 10);  chk("flip_d0", gdat(0), 12'h453);
      chk("flip_c1", gcol(1), 12);  chk("flip_d1", gdat(1), 12'h452);
      chk("flip_c2", gcol(2), 13);  chk("flip_d2", gdat(2), 12'h451);
      chk("flip_fa0", gfa(0), 32'h10100);
      chk("flip_fa1", gfa(1), 32'h100ff);

      // Horizontal flip with column wrap below zero
      start_cmd("hflip", 9'd0, 16'h0010, 4'd0, 2'd3, 6'h3f, 10'd0, 1'b1);
      wait_done("hflip");
      chk("hflip_nwr", wr_col.size(), 3);
      chk("hflip_c0", gcol(0), 0);    chk("hflip_d0", gdat(0), 12'hff1);
      chk("hflip_c1", gcol(1), 511);  chk("hflip_d1", gdat(1), 12'hff2);
      chk("hflip_c2", gcol(2), 510);  chk("hflip_d2", gdat(2), 12'hff3);

      // ROM stall: request held steady, a second command is ignored
      ok_delay = 20;
      start_cmd("stall", 9'd100, 16'h0200, 4'd1, 2'd2, 6'd9, 10'd0, 1'b0);
      bad = 0;
      for (int i = 0; i < 18; i++) begin
         if (i == 5) begin dr_start = 1'b1; dr_xpos = 9'd300; end
         if (i == 6) dr_start = 1'b0;
         if (!obj_cs || obj_addr !== 19'h08200 || bf_we) bad++;
         @(negedge clk);
      end
      chk("stall_stable", bad, 0);
      chk("stall_nowr", wr_col.size(), 0);
      wait_done("stall");
      ok_delay = 0;
      chk("stall_nwr", wr_col.size(), 1);
      chk("stall_c0", gcol(0), 100);
      chk("stall_d0", gdat(0), 12'h895);
      chk("stall_nfetch", fa.size(), 1);

      // Horizontal zoom: 16 drops every second pixel when enabled
      start_cmd("zoom", 9'd20, 16'h0300, 4'd0, 2'd0, 6'd1, 10'd16, 1'b0);
      wait_done("zoom");
`ifdef JTS16_OBJ_HZOOM_EN
      chk("zoom_nwr", wr_col.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("zoom_c%0d", i), gcol(i), 20 + i);
         chk($sformatf("zoom_d%0d", i), gdat(i), 12'h011);
      end
`else
      chk("zoom_nwr", wr_col.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("zoom_c%0d", i), gcol(i), 20 + i);
         chk($sformatf("zoom_d%0d", i), gdat(i), 12'h011);
      end
`endif

      // No end marker: forced stop after MAXWORDS (4) words
      start_cmd("maxw", 9'd0, 16'h0400, 4'd0, 2'd0, 6'd0, 10'd0, 1'b0);
      wait_done("maxw");
      chk("maxw_nfetch", fa.size(), 4);
      chk("maxw_lastfa", gfa(3), 32'h403);
      chk("maxw_nwr", wr_col.size(), 0);

      // Reset in the middle of a sprite
      start_cmd("rmid", 9'd50, 16'h0500, 4'd0, 2'd0, 6'd0, 10'd0, 1'b0);
      n = 0;
      while (!bf_we && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rmid_sawwr", bf_we, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rmid_we", bf_we, 0);
      chk("rmid_cs", obj_cs, 0);
      chk("rmid_busy", dr_busy, 0);
      repeat (3) @(negedge clk);
      chk("rmid_we_hold", bf_we, 0);
      rst_n = 1'b1;
      @(negedge clk);
      scen_a("post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
